// File: rtl/ula_arbiter.sv
// Two-requester ALU front end: arbitrates between requesters A and B, executes one
// MIPS-style ALU operation at a time and presents the result on a valid/ready port.
module ula_arbiter #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqA,
    input  logic [1:0]  aluOpA,
    input  logic [5:0]  functA,
    input  logic [31:0] in1A,
    input  logic [31:0] in2A,
    input  logic [4:0]  shamtA,
    input  logic        reqB,
    input  logic [1:0]  aluOpB,
    input  logic [5:0]  functB,
    input  logic [31:0] in1B,
    input  logic [31:0] in2B,
    input  logic [4:0]  shamtB,
    output logic        ackA,
    output logic        ackB,
    output logic        rspValid,
    input  logic        rspReady,
    output logic        rspId,
    output logic [31:0] rspResult,
    output logic        rspOverflow,
    output logic        rspIllegal,
    output logic        busy,
    output logic [15:0] opCount
);

    localparam int unsigned DW = 32;
    localparam int unsigned FW = 6;
    localparam int unsigned SW = 5;
    localparam int unsigned OW = 2;
    localparam int unsigned CW = 16;

    localparam logic [OW-1:0] OP_ADD   = 2'b00;
    localparam logic [OW-1:0] OP_AND   = 2'b01;
    localparam logic [OW-1:0] OP_RTYPE = 2'b10;

    localparam logic [FW-1:0] F_SLL = 6'd0;
    localparam logic [FW-1:0] F_SRL = 6'd2;
    localparam logic [FW-1:0] F_SRA = 6'd3;
    localparam logic [FW-1:0] F_ADD = 6'd32;
    localparam logic [FW-1:0] F_SUB = 6'd34;
    localparam logic [FW-1:0] F_AND = 6'd36;
    localparam logic [FW-1:0] F_OR  = 6'd37;
    localparam logic [FW-1:0] F_SLT = 6'd42;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic          last_grant;
    logic          any_req_c;
    logic          sel_b_c;
    logic          capture_c;
    logic          handshake_c;

    logic [OW-1:0] op_q;
    logic [FW-1:0] funct_q;
    logic [DW-1:0] in1_q;
    logic [DW-1:0] in2_q;
    logic [SW-1:0] shamt_q;
    logic          id_q;

    logic [DW-1:0] sum_c;
    logic [DW-1:0] diff_c;
    logic          add_ovf_c;
    logic          sub_ovf_c;
    logic          slt_c;
    logic [DW-1:0] alu_result_c;
    logic          alu_overflow_c;
    logic          alu_illegal_c;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        any_req_c   = reqA | reqB;
        sel_b_c     = reqB & (~reqA | ~last_grant);
        capture_c   = (state == IDLE) & any_req_c;
        handshake_c = (state == RESP) & rspValid & rspReady;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req_c) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (handshake_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture from the granted requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            funct_q    <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            shamt_q    <= '0;
            id_q       <= 1'b0;
            last_grant <= ~FIRST_PRIO;
        end else if (capture_c) begin
            op_q       <= sel_b_c ? aluOpB : aluOpA;
            funct_q    <= sel_b_c ? functB : functA;
            in1_q      <= sel_b_c ? in1B   : in1A;
            in2_q      <= sel_b_c ? in2B   : in2A;
            shamt_q    <= sel_b_c ? shamtB : shamtA;
            id_q       <= sel_b_c;
            last_grant <= sel_b_c;
        end
    end

    always_comb begin
        sum_c     = in1_q + in2_q;
        diff_c    = in1_q - in2_q;
        add_ovf_c = (in1_q[DW-1] == in2_q[DW-1]) & (sum_c[DW-1] != in1_q[DW-1]);
        sub_ovf_c = (in1_q[DW-1] != in2_q[DW-1]) & (diff_c[DW-1] != in1_q[DW-1]);
        slt_c     = $signed(in1_q) < $signed(in2_q);
    end

    // Undecodable operations still return the ADD sum, flagged illegal, with no overflow
    always_comb begin
        alu_result_c   = sum_c;
        alu_overflow_c = 1'b0;
        alu_illegal_c  = 1'b0;
        case (op_q)
            OP_ADD: alu_overflow_c = add_ovf_c;
            OP_AND: alu_result_c   = in1_q & in2_q;
            OP_RTYPE: begin
                case (funct_q)
                    F_SLL: alu_result_c = in1_q << shamt_q;
                    F_SRL: alu_result_c = in1_q >> shamt_q;
                    F_SRA: alu_result_c = DW'($signed(in1_q) >>> shamt_q);
                    F_ADD: alu_overflow_c = add_ovf_c;
                    F_SUB: begin
                        alu_result_c   = diff_c;
                        alu_overflow_c = sub_ovf_c;
                    end
                    F_AND: alu_result_c = in1_q & in2_q;
                    F_OR:  alu_result_c = in1_q | in2_q;
                    F_SLT: alu_result_c = {(DW-1)'(0), slt_c};
                    default: alu_illegal_c = 1'b1;
                endcase
            end
            default: alu_illegal_c = 1'b1;
        endcase
    end

    // Registered outputs; response fields only change on the EXEC->RESP edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ackA        <= 1'b0;
            ackB        <= 1'b0;
            rspValid    <= 1'b0;
            rspId       <= 1'b0;
            rspResult   <= '0;
            rspOverflow <= 1'b0;
            rspIllegal  <= 1'b0;
            busy        <= 1'b0;
            opCount     <= '0;
        end else begin
            busy <= (state_next != IDLE);
            ackA <= capture_c & ~sel_b_c;
            ackB <= capture_c & sel_b_c;
            if (state == EXEC) begin
                rspValid    <= 1'b1;
                rspId       <= id_q;
                rspResult   <= alu_result_c;
                rspOverflow <= alu_overflow_c;
                rspIllegal  <= alu_illegal_c;
            end else if (handshake_c) begin
                rspValid <= 1'b0;
                opCount  <= opCount + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Randomized scoreboard bench for ula_arbiter: stimulus pushes expected responses from a
// behavioural ALU/arbitration model; a separate monitor pops and compares them.
module tb_ula_arbiter;

    localparam bit FIRST_PRIO = 1'b0;

    logic        clk;
    logic        rst_n;
    logic        reqA, reqB;
    logic [1:0]  aluOpA, aluOpB;
    logic [5:0]  functA, functB;
    logic [31:0] in1A, in2A, in1B, in2B;
    logic [4:0]  shamtA, shamtB;
    logic        ackA, ackB;
    logic        rspValid, rspReady, rspId;
    logic [31:0] rspResult;
    logic        rspOverflow, rspIllegal, busy;
    logic [15:0] opCount;

    ula_arbiter #(.FIRST_PRIO(FIRST_PRIO)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqA(reqA), .aluOpA(aluOpA), .functA(functA), .in1A(in1A), .in2A(in2A), .shamtA(shamtA),
        .reqB(reqB), .aluOpB(aluOpB), .functB(functB), .in1B(in1B), .in2B(in2B), .shamtB(shamtB),
        .ackA(ackA), .ackB(ackB), .rspValid(rspValid), .rspReady(rspReady), .rspId(rspId),
        .rspResult(rspResult), .rspOverflow(rspOverflow), .rspIllegal(rspIllegal),
        .busy(busy), .opCount(opCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [1:0]  op;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
    } op_t;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        ovf;
        logic        ill;
    } rsp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    op_t  pend [2];
    bit   drv_v [2];
    int   wait_c [2];
    bit   last_g;
    bit   ack_prev;
    int   cyc = 0;
    int   ack_cyc = 0;
    rsp_t exp_q [$];
    bit   served [$];
    int   exp_cnt;
    bit   mon_presented;
    bit   mon_prev_valid;
    rsp_t mon_held;
    rsp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference ALU: classify the op, then compute with wide signed arithmetic
    function automatic rsp_t model(input op_t o, input bit id);
        rsp_t   r;
        longint sa, sb, wide;
        int     k;
        sa = longint'($signed(o.a));
        sb = longint'($signed(o.b));
        r.id = id; r.ovf = 1'b0; r.ill = 1'b0; r.res = o.a + o.b;
        case (o.op)
            2'b00: k = 0;
            2'b01: k = 2;
            2'b10: case (o.f)
                       6'd0:  k = 4;
                       6'd2:  k = 5;
                       6'd3:  k = 6;
                       6'd32: k = 0;
                       6'd34: k = 1;
                       6'd36: k = 2;
                       6'd37: k = 3;
                       6'd42: k = 7;
                       default: k = 8;
                   endcase
            default: k = 8;
        endcase
        case (k)
            0: begin wide = sa + sb; r.res = 32'(wide); r.ovf = (longint'($signed(r.res)) != wide); end
            1: begin wide = sa - sb; r.res = 32'(wide); r.ovf = (longint'($signed(r.res)) != wide); end
            2: r.res = o.a & o.b;
            3: r.res = o.a | o.b;
            4: r.res = o.a << o.sh;
            5: r.res = o.a >> o.sh;
            6: r.res = 32'(sa >>> o.sh);
            7: r.res = (sa < sb) ? 32'd1 : 32'd0;
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    function automatic op_t mk_op(input logic [1:0] op, input logic [5:0] f,
                                  input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        op_t o;
        o.v = 1'b1; o.op = op; o.f = f; o.a = a; o.b = b; o.sh = sh;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t         o;
        logic [5:0]  ft [9];
        logic [31:0] edge_v [5];
        ft     = '{6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd63};
        edge_v = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h0};
        o.v  = 1'b1;
        o.op = ($urandom_range(0, 9) < 6) ? 2'b10 : 2'($urandom_range(0, 3));
        o.f  = ft[$urandom_range(0, 8)];
        if ($urandom_range(0, 9) == 0) o.f = 6'($urandom);
        o.a  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
        o.b  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
        o.sh = 5'($urandom);
        return o;
    endfunction

    task automatic drive();
        reqA = pend[0].v; aluOpA = pend[0].op; functA = pend[0].f;
        in1A = pend[0].a; in2A = pend[0].b; shamtA = pend[0].sh;
        reqB = pend[1].v; aluOpB = pend[1].op; functB = pend[1].f;
        in1B = pend[1].a; in2B = pend[1].b; shamtB = pend[1].sh;
        drv_v[0] = pend[0].v;
        drv_v[1] = pend[1].v;
    endtask

    // One clock: check any capture against the arbitration model, then drive requests
    task automatic step();
        bit w, exp_w;
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (ackA || ackB) begin
                w     = ackB;
                exp_w = (drv_v[0] && drv_v[1]) ? !last_g : drv_v[1];
                chk("ack_onehot", 64'(ackA & ackB), 64'd0);
                chk("ack_grant", 64'(w), 64'(exp_w));
                chk("ack_single_cycle", 64'(ack_prev), 64'd0);
                chk("ack_pending", 64'(drv_v[w]), 64'd1);
                chk("ack_outside_resp", 64'(rspValid), 64'd0);
                chk("busy_exec", 64'(busy), 64'd1);
                if (drv_v[w]) begin
                    exp_q.push_back(model(pend[w], w));
                    served.push_back(w);
                    pend[w].v = 1'b0;
                    wait_c[w] = 0;
                    last_g    = w;
                    ack_cyc   = cyc;
                end
            end
            ack_prev = ackA || ackB;
            for (int i = 0; i < 2; i++) begin
                if (drv_v[i] && pend[i].v) begin
                    wait_c[i]++;
                    if (wait_c[i] > 60) begin
                        chk("ack_timeout", 64'(wait_c[i]), 64'd60);
                        pend[i].v = 1'b0;
                        wait_c[i] = 0;
                    end
                end
            end
        end
        #1;
        drive();
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        #2;
        chk("reset_ackA", 64'(ackA), 64'd0);
        chk("reset_ackB", 64'(ackB), 64'd0);
        chk("reset_rspValid", 64'(rspValid), 64'd0);
        chk("reset_rspId", 64'(rspId), 64'd0);
        chk("reset_rspResult", 64'(rspResult), 64'd0);
        chk("reset_rspOverflow", 64'(rspOverflow), 64'd0);
        chk("reset_rspIllegal", 64'(rspIllegal), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_opCount", 64'(opCount), 64'd0);
        exp_q.delete();
        last_g   = !FIRST_PRIO;
        ack_prev = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        rspReady = 1'b1;
        for (int k = 0; k < 120; k++) begin
            if (!pend[0].v && !pend[1].v && exp_q.size() == 0 && !rspValid) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk({"drain_", tag}, 64'(done), 64'd1);
    endtask

    task automatic run_op(input bit id, input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                          input string tag);
        pend[id] = mk_op(op, f, a, b, sh);
        drain(tag);
    endtask

    // Monitor: a handshake is seen one negedge later; new responses are popped and compared
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_presented  = 1'b0;
            mon_prev_valid = 1'b0;
            exp_cnt        = 0;
        end else begin
            if (mon_prev_valid && rspReady) begin
                exp_cnt++;
                mon_presented = 1'b0;
                chk("opcount", 64'(opCount), 64'(16'(exp_cnt)));
                chk("valid_drop", 64'(rspValid), 64'd0);
            end
            if (rspValid && !mon_presented) begin
                mon_presented = 1'b1;
                mon_held.id   = rspId;
                mon_held.res  = rspResult;
                mon_held.ovf  = rspOverflow;
                mon_held.ill  = rspIllegal;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: actual id=%0d result=%0h required=no response", rspId, rspResult);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_id", 64'(rspId), 64'(mon_e.id));
                    chk("rsp_result", 64'(rspResult), 64'(mon_e.res));
                    chk("rsp_overflow", 64'(rspOverflow), 64'(mon_e.ovf));
                    chk("rsp_illegal", 64'(rspIllegal), 64'(mon_e.ill));
                    chk("rsp_busy", 64'(busy), 64'd1);
                end
            end else if (rspValid) begin
                chk("hold_id", 64'(rspId), 64'(mon_held.id));
                chk("hold_result", 64'(rspResult), 64'(mon_held.res));
                chk("hold_overflow", 64'(rspOverflow), 64'(mon_held.ovf));
                chk("hold_illegal", 64'(rspIllegal), 64'(mon_held.ill));
            end
            mon_prev_valid = rspValid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=time limit reached required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int issue_c;
        int n_before;
        int sv;
        logic [15:0] hold_cnt;
        rst_n    = 1'b1;
        rspReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pend[i]   = '0;
            wait_c[i] = 0;
        end
        drive();
        do_reset();

        // Single A request: latency and first count
        pend[0] = mk_op(2'b10, 6'd32, 32'd7, 32'd5, 5'd0);
        issue_c = cyc;
        step();
        step();
        chk("lat_ack_cycle", 64'(ack_cyc), 64'(issue_c + 2));
        step();
        chk("lat_rsp_valid", 64'(rspValid), 64'd1);
        chk("lat_rsp_id", 64'(rspId), 64'd0);
        chk("lat_rsp_result", 64'(rspResult), 64'd12);
        chk("lat_rsp_overflow", 64'(rspOverflow), 64'd0);
        step();
        chk("lat_opcount", 64'(opCount), 64'd1);
        chk("lat_idle_valid", 64'(rspValid), 64'd0);

        // Both held continuously after reset: strict alternation starting at FIRST_PRIO
        do_reset();
        served.delete();
        for (int k = 0; k < 40 && served.size() < 4; k++) begin
            if (!pend[0].v) pend[0] = rand_op();
            if (!pend[1].v) pend[1] = rand_op();
            step();
        end
        drain("both");
        for (int i = 0; i < 4; i++) begin
            sv = (i < served.size()) ? int'(served[i]) : -1;
            chk("both_order", 64'(sv), 64'(i % 2));
        end

        // Boundary operations
        run_op(1'b0, 2'b10, 6'd32, 32'h7FFF_FFFF, 32'h1, 5'd0, "add_ovf");
        chk("add_ovf_result", 64'(mon_held.res), 64'h8000_0000);
        chk("add_ovf_flag", 64'(mon_held.ovf), 64'd1);
        run_op(1'b1, 2'b10, 6'd34, 32'h8000_0000, 32'h1, 5'd0, "sub_ovf");
        chk("sub_ovf_result", 64'(mon_held.res), 64'h7FFF_FFFF);
        chk("sub_ovf_flag", 64'(mon_held.ovf), 64'd1);
        chk("sub_ovf_id", 64'(mon_held.id), 64'd1);
        run_op(1'b0, 2'b10, 6'd2, 32'h8000_0000, 32'h0, 5'd4, "srl");
        chk("srl_result", 64'(mon_held.res), 64'h0800_0000);
        run_op(1'b1, 2'b10, 6'd3, 32'h8000_0000, 32'h0, 5'd4, "sra");
        chk("sra_result", 64'(mon_held.res), 64'hF800_0000);
        run_op(1'b0, 2'b10, 6'd42, 32'hFFFF_FFFF, 32'h1, 5'd0, "slt");
        chk("slt_result", 64'(mon_held.res), 64'd1);
        run_op(1'b1, 2'b10, 6'd63, 32'd3, 32'd4, 5'd0, "funct63");
        chk("funct63_illegal", 64'(mon_held.ill), 64'd1);
        chk("funct63_result", 64'(mon_held.res), 64'd7);
        run_op(1'b0, 2'b11, 6'd32, 32'd9, 32'd1, 5'd0, "op11");
        chk("op11_illegal", 64'(mon_held.ill), 64'd1);
        run_op(1'b1, 2'b01, 6'd0, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, "and");
        run_op(1'b0, 2'b10, 6'd0, 32'h0000_0001, 32'h0, 5'd31, "sll");

        // Backpressure: response held, second request must wait
        rspReady = 1'b0;
        pend[0]  = rand_op();
        for (int k = 0; k < 10 && !rspValid; k++) step();
        pend[1]  = rand_op();
        hold_cnt = opCount;
        n_before = served.size();
        repeat (5) step();
        chk("bp_valid", 64'(rspValid), 64'd1);
        chk("bp_no_ack", 64'(served.size()), 64'(n_before));
        chk("bp_opcount", 64'(opCount), 64'(hold_cnt));
        drain("bp");

        // Reset in RESP abandons the response; pending B is re-arbitrated afterwards
        rspReady = 1'b0;
        pend[0]  = rand_op();
        for (int k = 0; k < 10 && !rspValid; k++) step();
        pend[1] = rand_op();
        step();
        step();
        do_reset();
        drain("post_reset");
        chk("post_reset_opcount", 64'(opCount), 64'd1);
        chk("post_reset_served", 64'(served[served.size() - 1]), 64'd1);

        // Random traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            rspReady = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i].v && $urandom_range(0, 2) == 0) pend[i] = rand_op();
            end
            step();
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
